// File: rtl/ps2_kbd_port_if.sv
// ps2_kbd_port_if: CPU-side control signals of the PS/2 keyboard port.
// The 32-bit shared data bus stays a plain inout on the design so that its
// tri-state resolution lives at a single level of hierarchy.
//   sel      chip select (Addr[31:28] == 4'hB)
//   Addrin   register select (Addr[3:2])
//   Memread  read strobe, may be held for several cycles
//   Memwrite write strobe, any nonzero value means write
//   irq      high while the scan-code FIFO is not empty
interface ps2_kbd_port_if;
  logic       sel;
  logic [1:0] Addrin;
  logic       Memread;
  logic [1:0] Memwrite;
  logic       irq;

  modport master (output sel, output Addrin, output Memread, output Memwrite, input irq);
  modport slave  (input sel, input Addrin, input Memread, input Memwrite, output irq);
endinterface

// File: rtl/ps2_kbd_port.sv
// ps2_kbd_port: memory-mapped PS/2 keyboard receiver.
// Synchronises the raw PS/2 lines, deserialises 11-bit device frames,
// checks start/parity/stop framing and buffers good scan codes in a FIFO
// that the CPU pops through the DATA register.
//   clk, rst  CPU clock, asynchronous active-high reset
//   ps2_clk   raw PS/2 clock (asynchronous)
//   ps2_data  raw PS/2 data (asynchronous)
//   cpu       slave side of ps2_kbd_port_if (sel/Addrin/Memread/Memwrite/irq)
//   BUS       shared data bus, driven only while sel && Memread
// Registers: 0 DATA {23'b0, valid, head}, 1 STATUS {count, ovf, perr, full,
// empty} (write clears ovf/perr), 2/3 read as zero.
module ps2_kbd_port #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 25000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_kbd_port_if.slave     cpu,
  inout  wire  [31:0]       BUS
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // A frame is good when the stop bit is 1 and data plus parity is odd.
  function automatic logic frame_ok(input logic [7:0] d, input logic par, input logic stop);
    return stop & (^{par, d});
  endfunction

  // Synchroniser and edge-detect state
  logic pclk_s1_q, pclk_s2_q, pclk_s3_q, fall_q;
  logic pdat_s1_q, pdat_s2_q;

  // Receive FSM state
  logic [1:0]      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            push_s, perr_set_s;

  // FIFO and register state
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, perr_q, irq_q, rd_prev_q;
  logic [31:0]      rd_data_q;

  logic        empty_s, full_s, pop_s, push_ok_s, ovf_set_s, flag_clr_s;
  logic        data_rd_s, first_s;
  logic [31:0] head_word_s, bus_out_s;

  assign empty_s    = (count_q == CNT_W'(0));
  assign full_s     = (count_q == CNT_W'(FIFO_DEPTH));
  assign data_rd_s  = cpu.sel && cpu.Memread && (cpu.Addrin == 2'd0);
  // Only the rising edge of a DATA read strobe pops; a held strobe does not.
  assign first_s    = data_rd_s && !rd_prev_q;
  assign pop_s      = first_s && !empty_s;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok_s  = push_s && (!full_s || pop_s);
  assign ovf_set_s  = push_s && full_s && !pop_s;
  assign flag_clr_s = cpu.sel && (cpu.Memwrite != 2'd0) && (cpu.Addrin == 2'd1);
  assign head_word_s = empty_s ? 32'd0 : {23'd0, 1'b1, mem_q[rd_ptr_q]};

  // PS/2 line synchronisers; fall_q pulses one cycle per ps2_clk 1->0 edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_s1_q <= 1'b1;
      pclk_s2_q <= 1'b1;
      pclk_s3_q <= 1'b1;
      pdat_s1_q <= 1'b1;
      pdat_s2_q <= 1'b1;
      fall_q    <= 1'b0;
    end else begin
      pclk_s1_q <= ps2_clk;
      pclk_s2_q <= pclk_s1_q;
      pclk_s3_q <= pclk_s2_q;
      pdat_s1_q <= ps2_data;
      pdat_s2_q <= pdat_s1_q;
      fall_q    <= pclk_s3_q & ~pclk_s2_q;
    end
  end

  // Receive FSM next-state logic including the mid-frame timeout
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    to_cnt_d   = to_cnt_q;
    push_s     = 1'b0;
    perr_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_q && !pdat_s2_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_q) begin
          shift_d   = {pdat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_q) begin
          par_d   = pdat_s2_q;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fall_q) begin
          if (frame_ok(shift_q, par_q, pdat_s2_q)) begin
            push_s = 1'b1;
          end else begin
            perr_set_s = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Timeout overrides anything the edge would have done this cycle.
    if (state_q == ST_IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TIMEOUT)) begin
      state_d    = ST_IDLE;
      to_cnt_d   = '0;
      push_s     = 1'b0;
      perr_set_s = 1'b1;
    end else if (fall_q) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Receive FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // FIFO occupancy next value
  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // FIFO pointers, sticky flags, irq and read-strobe tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      perr_q    <= 1'b0;
      irq_q     <= 1'b0;
      rd_prev_q <= 1'b0;
      rd_data_q <= 32'd0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_s)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q   <= count_d;
      // Set beats a same-cycle clear so an error is never silently lost.
      ovf_q     <= ovf_set_s  | (ovf_q  & ~flag_clr_s);
      perr_q    <= perr_set_s | (perr_q & ~flag_clr_s);
      irq_q     <= (count_d != CNT_W'(0));
      rd_prev_q <= data_rd_s;
      if (first_s) rd_data_q <= head_word_s;
    end
  end

  // Read mux: DATA shows the head latched at the first strobe cycle
  always_comb begin
    bus_out_s = 32'd0;
    case (cpu.Addrin)
      2'd0:    bus_out_s = first_s ? head_word_s : rd_data_q;
      2'd1:    bus_out_s = {24'd0, 4'(count_q), ovf_q, perr_q, full_s, empty_s};
      default: bus_out_s = 32'd0;
    endcase
  end

  assign BUS     = (cpu.sel && cpu.Memread) ? bus_out_s : 32'bz;
  assign cpu.irq = irq_q;

endmodule

// File: tb/tb_ps2_kbd_port.sv
module tb_ps2_kbd_port;
  localparam int DEPTH = 8;
  localparam int TO    = 100;
  localparam int HALF  = 20;   // clk is 1 us, so a PS/2 period is 40 us

  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data;
  wire [31:0] BUS;
  ps2_kbd_port_if cpu_if();

  ps2_kbd_port #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .cpu(cpu_if), .BUS(BUS)
  );

  always #500 clk = ~clk;

  initial begin
    #60000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // Reference model: a byte queue plus two sticky flags
  logic [7:0] mq[$];
  bit m_ovf, m_perr;

  typedef struct {
    logic [7:0]  d;
    bit          bad;
    logic [31:0] st1;
    logic [31:0] dat;
    logic [31:0] st2;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_frame(input logic [7:0] d, input bit bad);
    if (bad) m_perr = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(d);
    else m_ovf = 1'b1;
  endtask

  function automatic logic [31:0] model_status();
    logic [3:0] c;
    c = 4'(mq.size());
    return {24'd0, c, m_ovf, m_perr, mq.size() == DEPTH, mq.size() == 0};
  endfunction

  task automatic model_pop(output logic [31:0] v);
    if (mq.size() == 0) v = 32'd0;
    else v = {23'd0, 1'b1, mq.pop_front()};
  endtask

  // Device-side frame: data changes while ps2_clk is high, sampled on fall
  task automatic send_frame(input logic [7:0] d, input bit bad, input int nbits, input bit lat);
    logic [10:0] fr;
    logic par;
    par = 1'(~(^d)) ^ bad;
    fr = {1'b1, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      step(HALF);
      ps2_clk = 1'b0;
      if (lat && i == 10) begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("irq_lat3", {31'd0, cpu_if.irq}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("irq_lat4", {31'd0, cpu_if.irq}, 32'd1);
        @(posedge clk); #1;
        step(HALF - 5);
      end else begin
        step(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    step(HALF);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] v);
    cpu_if.sel = 1'b1; cpu_if.Addrin = a; cpu_if.Memread = 1'b1;
    @(negedge clk);
    v = BUS;
    @(posedge clk); #1;
    cpu_if.sel = 1'b0; cpu_if.Memread = 1'b0;
    step(1);
  endtask

  task automatic bus_wr_status();
    cpu_if.sel = 1'b1; cpu_if.Addrin = 2'd1; cpu_if.Memwrite = 2'b01;
    step(1);
    cpu_if.sel = 1'b0; cpu_if.Memwrite = 2'b00;
    step(1);
    m_ovf = 1'b0; m_perr = 1'b0;
  endtask

  task automatic chk_data(input string name);
    logic [31:0] v, e;
    bus_rd(2'd0, v);
    model_pop(e);
    chk(name, v, e);
  endtask

  task automatic chk_status(input string name);
    logic [31:0] v;
    bus_rd(2'd1, v);
    chk(name, v, model_status());
  endtask

  initial begin
    logic [31:0] v;
    tbl[0] = '{8'h1C, 1'b0, 32'h10, 32'h11C, 32'h01};
    tbl[1] = '{8'hF0, 1'b1, 32'h05, 32'h000, 32'h05};
    tbl[2] = '{8'h00, 1'b0, 32'h10, 32'h100, 32'h01};
    tbl[3] = '{8'hFF, 1'b0, 32'h10, 32'h1FF, 32'h01};
    tbl[4] = '{8'hA5, 1'b1, 32'h05, 32'h000, 32'h05};
    tbl[5] = '{8'h5A, 1'b0, 32'h10, 32'h15A, 32'h01};

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    cpu_if.sel = 1'b0; cpu_if.Addrin = 2'd0; cpu_if.Memread = 1'b0; cpu_if.Memwrite = 2'd0;
    step(3);
    rst = 1'b0;
    step(2);

    // Reset state
    chk("reset_irq", {31'd0, cpu_if.irq}, 32'd0);
    bus_rd(2'd1, v); chk("reset_status", v, 32'h01);
    bus_rd(2'd0, v); chk("reset_data", v, 32'h000);
    bus_rd(2'd2, v); chk("reg2_zero", v, 32'd0);
    bus_rd(2'd3, v); chk("reg3_zero", v, 32'd0);

    // Table of single frames, each starting from an empty FIFO and clear flags
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].d, tbl[i].bad, 11, i == 0);
      model_frame(tbl[i].d, tbl[i].bad);
      bus_rd(2'd1, v); chk("tbl_status1", v, tbl[i].st1);
      bus_rd(2'd0, v); chk("tbl_data", v, tbl[i].dat);
      model_pop(v);
      bus_rd(2'd1, v); chk("tbl_status2", v, tbl[i].st2);
      bus_wr_status();
    end
    bus_rd(2'd1, v); chk("clear_status", v, 32'h01);

    // Overflow: nine frames into an eight-deep FIFO
    for (int k = 1; k <= 9; k++) begin
      send_frame(8'(k), 1'b0, 11, 1'b0);
      model_frame(8'(k), 1'b0);
    end
    bus_rd(2'd1, v); chk("ovf_status", v, 32'h8A);
    for (int k = 1; k <= 9; k++) chk_data("ovf_drain");
    bus_wr_status();
    bus_rd(2'd1, v); chk("ovf_cleared", v, 32'h01);

    // Held read strobe pops exactly once and keeps the pre-pop head on the bus
    send_frame(8'h33, 1'b0, 11, 1'b0); model_frame(8'h33, 1'b0);
    send_frame(8'h44, 1'b0, 11, 1'b0); model_frame(8'h44, 1'b0);
    bus_rd(2'd1, v); chk("held_pre_count", v, 32'h20);
    cpu_if.sel = 1'b1; cpu_if.Addrin = 2'd0; cpu_if.Memread = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("held_bus", BUS, 32'h133);
      @(posedge clk); #1;
    end
    cpu_if.sel = 1'b0; cpu_if.Memread = 1'b0;
    step(1);
    model_pop(v);
    bus_rd(2'd1, v); chk("held_post_count", v, 32'h10);
    chk_data("held_next");

    // Timeout after four data bits, then a good frame
    send_frame(8'h77, 1'b0, 5, 1'b0);
    step(TO + 30);
    m_perr = 1'b1;
    bus_rd(2'd1, v); chk("timeout_status", v, 32'h05);
    bus_wr_status();
    send_frame(8'h5A, 1'b0, 11, 1'b0); model_frame(8'h5A, 1'b0);
    bus_rd(2'd0, v); chk("after_timeout", v, 32'h15A);
    model_pop(v);
    chk_status("after_timeout_status");

    // Randomised frames and CPU accesses against the queue model
    for (int it = 0; it < 14; it++) begin
      logic [7:0] d;
      bit bad;
      d = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(d, bad, 11, 1'b0);
      model_frame(d, bad);
      for (int r = 0; r < int'($urandom_range(0, 2)); r++) begin
        if ($urandom_range(0, 1) == 0) chk_data("rnd_data");
        else chk_status("rnd_status");
      end
      if ($urandom_range(0, 3) == 0) bus_wr_status();
      chk("rnd_irq", {31'd0, cpu_if.irq}, {31'd0, mq.size() != 0});
    end
    chk_status("rnd_pre_drain");
    for (int k = 0; k <= DEPTH; k++) chk_data("rnd_drain");
    chk_status("rnd_final");

    // Asynchronous reset mid-frame discards FIFO contents and flags
    send_frame(8'h12, 1'b0, 11, 1'b0); model_frame(8'h12, 1'b0);
    send_frame(8'h34, 1'b0, 4, 1'b0);
    #200;
    rst = 1'b1;
    #100;
    chk("midrst_irq", {31'd0, cpu_if.irq}, 32'd0);
    step(2);
    rst = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_perr = 1'b0;
    step(2);
    bus_rd(2'd1, v); chk("midrst_status", v, 32'h01);
    send_frame(8'h3C, 1'b0, 11, 1'b0); model_frame(8'h3C, 1'b0);
    bus_rd(2'd0, v); chk("midrst_recover", v, 32'h13C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_port.md
# ps2_kbd_port

Memory-mapped PS/2 keyboard receiver on the CPU data bus, decoded at `Addr[31:28] == 4'hB`. It is the input-side counterpart of the VGA video-memory window. It deserialises PS/2 device frames, checks parity and framing, and buffers good scan-code bytes in a FIFO. The CPU reads them over the shared `BUS` using the same `Memread`/`Memwrite` strobes that `Mem` uses.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: scan-code FIFO entries; must be a power of 2, ≥2.
- `TIMEOUT`, default 25000: CPU-clock cycles with no PS/2 falling edge mid-frame before the frame is aborted.

Ports:
- `clk`  in  1  CPU clock. Single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clk`.
- `sel`  in  1  chip select; the top level drives it as `Addr[31:28] == 4'hB`.
- `Addrin`  in  2  register select, `Addr[3:2]`.
- `Memread`  in  1  read strobe. May be held for several cycles.
- `Memwrite`  in  2  write strobe; any nonzero value means write.
- `BUS`  inout  32  shared data bus. Driven only while `sel && Memread`; otherwise `32'bz`.
- `irq`  out  1  high while the FIFO is not empty.

## Operation
Input synchronisation:
- `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
- A third flop on `ps2_clk` is used for edge detection.
- `fall` is asserted for one cycle when the synchronised clock goes 1→0. Data is sampled on `fall`.

Receive FSM:
- IDLE:
  - On `fall` with data=0 (start bit), go to DATA and clear the bit counter.
  - On `fall` with data=1, stay in IDLE (glitch).
- DATA: shift in 8 bits, LSB first, one per `fall`. After the 8th bit, go to PARITY.
- PARITY: capture the bit on `fall`; go to STOP.
- STOP: on `fall`, the frame is good when the stop bit is 1 and the 8 data bits plus the parity bit have odd parity.
  - Good frame: push the byte into the FIFO and return to IDLE.
  - Bad frame: set sticky `perr`, push nothing, return to IDLE.
- Timeout: in any state other than IDLE, a counter increments every cycle and clears on each `fall`.
  - When it reaches `TIMEOUT`, go to IDLE, discard the partial frame, set `perr`.
  - Width is `$clog2(TIMEOUT+1)`; the counter saturates and does not wrap.

FIFO:
- Depth `FIFO_DEPTH`. Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap modulo depth. Count is one bit wider.
- Push while full: the byte is dropped, sticky `ovf` is set, and FIFO contents are unchanged.
- Pop while empty: no effect.
- Push and pop in the same cycle when not empty and not full: count is unchanged and both pointers advance.
- Push and pop in the same cycle when full: the pop frees a slot, so the push is accepted and `ovf` is not set.

Register map (`Addrin`):
- 0, DATA (read):
  - Returns `{23'b0, valid, head_byte}`, where `valid = !empty`.
  - Pops exactly once per read strobe: on the first cycle of `sel && Memread && Addrin==0`, detected as the strobe being high this cycle and low the previous cycle. A held `Memread` does not pop again.
  - `BUS` shows the pre-pop head for the whole strobe; the head is latched on the first cycle.
- 1, STATUS:
  - Read returns `{24'b0, count[3:0], ovf, perr, full, empty}`.
  - Any write clears `ovf` and `perr`. Write data is ignored.
- 2, 3: read as 0. Writes are ignored.

## Timing
- Reset values:
  - FSM = IDLE; FIFO empty; `ovf = perr = 0`; `irq = 0`.
  - `BUS` = Z; all synchronisers = 1 (idle bus).
- Latency from the stop-bit `ps2_clk` falling edge at the pin to `irq` high: 4 `clk` cycles (2 sync + edge detect + FIFO write).
- Pop takes effect at the clock edge ending the first strobe cycle. `count` and `irq` update on the next cycle.
- Sticky-flag set by the FSM and clear by a CPU write in the same cycle: set wins.
- `rst` asserted mid-frame or mid-read: the block returns to reset values immediately and asynchronously, and the FIFO contents are discarded.

## Test plan
- Reset then idle lines: STATUS reads `0x01` (empty), `irq = 0`, and DATA reads `0x000`.
- Send frame 0x1C with correct parity (parity bit 0), `ps2_clk` period 40 µs → `irq` rises 4 cycles after the stop edge. DATA read returns `0x11C`. STATUS then reads `0x01`.
- Send 0xF0 with the parity bit inverted → FIFO stays empty and STATUS = `0x05`. Write STATUS → reads `0x01`.
- Send 9 good bytes 0x01..0x09 with no reads → STATUS = `0x8A` (count 8, ovf, full). Eight DATA reads return 0x01..0x08; the ninth returns `0x000`.
- Hold `Memread` for 5 cycles on DATA with 2 bytes queued → exactly one pop, and count goes 2→1.
- Stop `ps2_clk` after 4 data bits for more than `TIMEOUT` cycles → `perr` set, FSM returns to IDLE. A following good frame 0x5A is received correctly.
